// File: rtl/ibex_pkg.sv
// Shared types for the crypto writeback stage: instruction class and FSM states.
package ibex_pkg;

    typedef enum logic [1:0] {
        WB_INSTR_LOAD  = 2'd0,
        WB_INSTR_STORE = 2'd1,
        WB_INSTR_OTHER = 2'd2
    } wb_instr_type_e;

    typedef enum logic [1:0] {
        WB_IDLE     = 2'd0,
        WB_OTHER    = 2'd1,
        WB_LSU_WAIT = 2'd2
    } wb_state_e;

endpackage

// File: rtl/ibex_crypto_wb_stage.sv
// Writeback stage behind the crypto-enabled execute block. Holds one completing
// instruction, waits on the LSU for loads/stores, drives the register-file write
// port, forwarding data, retire pulse and a saturating LSU stall-cycle counter.
module ibex_crypto_wb_stage
    import ibex_pkg::*;
#(
    parameter int unsigned RegAddrW  = 5,
    parameter int unsigned StallCntW = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_wb_i,
    input  logic [1:0]           instr_type_wb_i,
    input  logic                 rf_we_id_i,
    input  logic [RegAddrW-1:0]  rf_waddr_id_i,
    input  logic [31:0]          rf_wdata_ex_i,
    input  logic                 lsu_resp_valid_i,
    input  logic                 lsu_resp_err_i,
    input  logic [31:0]          lsu_rdata_i,
    output logic                 ready_wb_o,
    output logic                 rf_we_o,
    output logic [RegAddrW-1:0]  rf_waddr_o,
    output logic [31:0]          rf_wdata_o,
    output logic [31:0]          rf_wdata_fwd_o,
    output logic                 rf_write_wb_o,
    output logic                 outstanding_load_o,
    output logic                 instr_done_o,
    output logic                 instr_err_o,
    output logic                 lsu_resp_unexp_o,
    output logic [StallCntW-1:0] stall_cnt_o
);

    localparam logic [StallCntW-1:0] StallMax = {StallCntW{1'b1}};
    localparam logic [StallCntW-1:0] StallOne = {{(StallCntW-1){1'b0}}, 1'b1};

    wb_state_e            state_q, state_d;
    logic                 valid_q;
    wb_instr_type_e       type_q, type_d;
    logic                 we_q;
    logic [RegAddrW-1:0]  waddr_q;
    logic [31:0]          wdata_q;
    logic [StallCntW-1:0] stall_cnt_q;

    logic in_lsu_wait;
    logic accept;
    logic rd_nonzero;
    logic is_load_q;

    // Classify the incoming instruction; the unused encoding is treated as OTHER.
    always_comb begin
        type_d = WB_INSTR_OTHER;
        if (instr_type_wb_i == WB_INSTR_LOAD) begin
            type_d = WB_INSTR_LOAD;
        end else if (instr_type_wb_i == WB_INSTR_STORE) begin
            type_d = WB_INSTR_STORE;
        end
    end

    assign in_lsu_wait = (state_q == WB_LSU_WAIT);
    assign is_load_q   = (type_q == WB_INSTR_LOAD);
    assign rd_nonzero  = (waddr_q != '0);

    // OTHER retires in its only cycle; LSU ops retire when the response arrives.
    assign instr_done_o = (state_q == WB_OTHER) || (in_lsu_wait && lsu_resp_valid_i);
    assign ready_wb_o   = !valid_q || instr_done_o;
    assign accept       = en_wb_i && ready_wb_o;

    assign rf_write_wb_o      = valid_q && we_q && rd_nonzero;
    assign outstanding_load_o = in_lsu_wait && is_load_q && !lsu_resp_valid_i;
    assign instr_err_o        = in_lsu_wait && lsu_resp_valid_i && lsu_resp_err_i;
    // A response with nothing waiting on it is flagged and otherwise ignored.
    assign lsu_resp_unexp_o   = lsu_resp_valid_i && !in_lsu_wait;
    assign stall_cnt_o        = stall_cnt_q;
    assign rf_waddr_o         = waddr_q;
    assign rf_wdata_fwd_o     = rf_wdata_o;

    // Register-file write: x0 never written, stores never write, erroring loads dropped;
    // data is forced to zero when no write happens so nothing leaks onto the port.
    always_comb begin
        rf_we_o    = 1'b0;
        rf_wdata_o = 32'h0;
        if (state_q == WB_OTHER) begin
            rf_we_o = we_q && rd_nonzero;
        end else if (in_lsu_wait && is_load_q) begin
            rf_we_o = lsu_resp_valid_i && !lsu_resp_err_i && we_q && rd_nonzero;
        end
        if (rf_we_o) begin
            rf_wdata_o = is_load_q ? lsu_rdata_i : wdata_q;
        end
    end

    // Next state: once the entry frees up, go wherever the newly accepted op leads.
    always_comb begin
        state_d = state_q;
        if (!valid_q || instr_done_o) begin
            if (accept) begin
                state_d = (type_d == WB_INSTR_OTHER) ? WB_OTHER : WB_LSU_WAIT;
            end else begin
                state_d = WB_IDLE;
            end
        end
    end

    // State register and entry valid flag.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= WB_IDLE;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= accept || (valid_q && !instr_done_o);
        end
    end

    // Entry payload captured on accept.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            type_q  <= WB_INSTR_OTHER;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= 32'h0;
        end else if (accept) begin
            type_q  <= type_d;
            we_q    <= rf_we_id_i;
            waddr_q <= rf_waddr_id_i;
            wdata_q <= rf_wdata_ex_i;
        end
    end

    // Stall counter: cleared on accept, counts response-less LSU wait cycles, saturates.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
        end else if (accept) begin
            stall_cnt_q <= '0;
        end else if (in_lsu_wait && !lsu_resp_valid_i && (stall_cnt_q != StallMax)) begin
            stall_cnt_q <= stall_cnt_q + StallOne;
        end
    end

endmodule

// File: tb/tb_ibex_crypto_wb_stage.sv
// Scoreboard bench for the writeback stage: stimulus pushes expected retire/unexpected
// events, a negedge monitor pops and compares whenever the DUT presents one.
module tb_ibex_crypto_wb_stage;
    import ibex_pkg::*;

    localparam int unsigned RegAddrW  = 5;
    localparam int unsigned StallCntW = 4;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 en_wb = 1'b0;
    logic [1:0]           instr_type = 2'd2;
    logic                 rf_we_id = 1'b0;
    logic [RegAddrW-1:0]  rf_waddr_id = '0;
    logic [31:0]          rf_wdata_ex = 32'h0;
    logic                 lsu_resp_valid = 1'b0;
    logic                 lsu_resp_err = 1'b0;
    logic [31:0]          lsu_rdata = 32'h0;
    logic                 ready_wb;
    logic                 rf_we;
    logic [RegAddrW-1:0]  rf_waddr;
    logic [31:0]          rf_wdata;
    logic [31:0]          rf_wdata_fwd;
    logic                 rf_write_wb;
    logic                 outstanding_load;
    logic                 instr_done;
    logic                 instr_err;
    logic                 lsu_resp_unexp;
    logic [StallCntW-1:0] stall_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic        done;
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        err;
        logic        unexp;
        logic        chk_stall;
        logic [3:0]  stall;
    } exp_t;

    exp_t exp_q[$];

    ibex_crypto_wb_stage #(
        .RegAddrW  (RegAddrW),
        .StallCntW (StallCntW)
    ) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .en_wb_i            (en_wb),
        .instr_type_wb_i    (instr_type),
        .rf_we_id_i         (rf_we_id),
        .rf_waddr_id_i      (rf_waddr_id),
        .rf_wdata_ex_i      (rf_wdata_ex),
        .lsu_resp_valid_i   (lsu_resp_valid),
        .lsu_resp_err_i     (lsu_resp_err),
        .lsu_rdata_i        (lsu_rdata),
        .ready_wb_o         (ready_wb),
        .rf_we_o            (rf_we),
        .rf_waddr_o         (rf_waddr),
        .rf_wdata_o         (rf_wdata),
        .rf_wdata_fwd_o     (rf_wdata_fwd),
        .rf_write_wb_o      (rf_write_wb),
        .outstanding_load_o (outstanding_load),
        .instr_done_o       (instr_done),
        .instr_err_o        (instr_err),
        .lsu_resp_unexp_o   (lsu_resp_unexp),
        .stall_cnt_o        (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic we, input logic [4:0] addr, input logic [31:0] data,
                                input logic err, input logic [3:0] stall);
        exp_t e;
        e.done = 1'b1; e.we = we; e.addr = addr; e.data = data; e.err = err;
        e.unexp = 1'b0; e.chk_stall = 1'b1; e.stall = stall;
        return e;
    endfunction

    function automatic exp_t mk_unexp();
        exp_t e;
        e.done = 1'b0; e.we = 1'b0; e.addr = 5'd0; e.data = 32'h0; e.err = 1'b0;
        e.unexp = 1'b1; e.chk_stall = 1'b0; e.stall = 4'd0;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] ty, input logic we, input logic [4:0] addr,
                         input logic [31:0] data);
        en_wb = 1'b1; instr_type = ty; rf_we_id = we; rf_waddr_id = addr; rf_wdata_ex = data;
    endtask

    task automatic idle_in();
        en_wb = 1'b0; rf_we_id = 1'b0; rf_waddr_id = '0; rf_wdata_ex = 32'h0;
    endtask

    // Monitor: every retire or unexpected-response cycle consumes one scoreboard entry.
    always @(negedge clk) begin
        if (!rst && (instr_done || lsu_resp_unexp || rf_we)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_event", {29'h0, instr_done, lsu_resp_unexp, rf_we}, 32'h0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                $display("txn t=%0t done=%0b we=%0b addr=%0d data=0x%08h err=%0b unexp=%0b stall=%0d",
                         $time, instr_done, rf_we, rf_waddr, rf_wdata, instr_err, lsu_resp_unexp, stall_cnt);
                check("done", {31'h0, instr_done}, {31'h0, e.done});
                check("rf_we", {31'h0, rf_we}, {31'h0, e.we});
                check("instr_err", {31'h0, instr_err}, {31'h0, e.err});
                check("unexp", {31'h0, lsu_resp_unexp}, {31'h0, e.unexp});
                if (e.we) begin
                    check("waddr", {27'h0, rf_waddr}, {27'h0, e.addr});
                    check("wdata", rf_wdata, e.data);
                    check("fwd", rf_wdata_fwd, e.data);
                end else begin
                    check("wdata_zero", rf_wdata, 32'h0);
                end
                if (e.chk_stall) check("stall_at_retire", {28'h0, stall_cnt}, {28'h0, e.stall});
            end
        end
    end

    // Protocol watchdog: EX must never present an instruction WB cannot take.
    always @(negedge clk) begin
        if (!rst && en_wb && !ready_wb) check("protocol_en_when_not_ready", {31'h0, ready_wb}, 32'h1);
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", {31'h0, ready_wb}, 32'h1);
        check("rst_rf_we", {31'h0, rf_we}, 32'h0);
        check("rst_done", {31'h0, instr_done}, 32'h0);
        check("rst_outstanding", {31'h0, outstanding_load}, 32'h0);
        check("rst_stall", {28'h0, stall_cnt}, 32'h0);
        tick();
        rst = 1'b0;
        tick();

        // Back-to-back OTHER writes
        issue(WB_INSTR_OTHER, 1'b1, 5'd5, 32'h0000_1234);
        exp_q.push_back(mk(1'b1, 5'd5, 32'h0000_1234, 1'b0, 4'd0));
        @(negedge clk); check("b2b_ready0", {31'h0, ready_wb}, 32'h1);
        tick();
        issue(WB_INSTR_OTHER, 1'b1, 5'd6, 32'hCAFE_F00D);
        exp_q.push_back(mk(1'b1, 5'd6, 32'hCAFE_F00D, 1'b0, 4'd0));
        @(negedge clk); check("b2b_ready1", {31'h0, ready_wb}, 32'h1);
        tick();
        idle_in();
        @(negedge clk); check("b2b_ready2", {31'h0, ready_wb}, 32'h1);
        tick();

        // Load with three wait cycles
        issue(WB_INSTR_LOAD, 1'b1, 5'd7, 32'h5555_5555);
        exp_q.push_back(mk(1'b1, 5'd7, 32'hFFFF_FF80, 1'b0, 4'd3));
        tick();
        idle_in();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("load_outstanding", {31'h0, outstanding_load}, 32'h1);
            check("load_ready", {31'h0, ready_wb}, 32'h0);
            check("load_write_wb", {31'h0, rf_write_wb}, 32'h1);
            tick();
        end
        lsu_resp_valid = 1'b1; lsu_rdata = 32'hFFFF_FF80;
        @(negedge clk); check("load_resp_outstanding", {31'h0, outstanding_load}, 32'h0);
        tick();
        lsu_resp_valid = 1'b0; lsu_rdata = 32'h0;
        tick();

        // Load with bus error
        issue(WB_INSTR_LOAD, 1'b1, 5'd9, 32'h0);
        exp_q.push_back(mk(1'b0, 5'd9, 32'h0, 1'b1, 4'd0));
        tick();
        idle_in();
        lsu_resp_valid = 1'b1; lsu_resp_err = 1'b1; lsu_rdata = 32'h1234_5678;
        tick();
        lsu_resp_valid = 1'b0; lsu_resp_err = 1'b0; lsu_rdata = 32'h0;
        tick();

        // x0 write suppressed, then a store answered after one wait cycle
        issue(WB_INSTR_OTHER, 1'b1, 5'd0, 32'h0000_DEAD);
        exp_q.push_back(mk(1'b0, 5'd0, 32'h0, 1'b0, 4'd0));
        tick();
        issue(WB_INSTR_STORE, 1'b0, 5'd11, 32'h0);
        exp_q.push_back(mk(1'b0, 5'd11, 32'h0, 1'b0, 4'd1));
        tick();
        idle_in();
        tick();
        lsu_resp_valid = 1'b1;
        tick();
        lsu_resp_valid = 1'b0;
        tick();

        // Unexpected response while idle
        lsu_resp_valid = 1'b1; lsu_rdata = 32'h0000_0BAD;
        exp_q.push_back(mk_unexp());
        tick();
        lsu_resp_valid = 1'b0; lsu_rdata = 32'h0;
        tick();

        // Reset in the middle of a load
        issue(WB_INSTR_LOAD, 1'b1, 5'd3, 32'h0);
        tick();
        idle_in();
        tick();
        rst = 1'b1;
        #1;
        check("midrst_ready", {31'h0, ready_wb}, 32'h1);
        check("midrst_outstanding", {31'h0, outstanding_load}, 32'h0);
        check("midrst_rf_we", {31'h0, rf_we}, 32'h0);
        check("midrst_write_wb", {31'h0, rf_write_wb}, 32'h0);
        tick();
        rst = 1'b0;
        tick();
        lsu_resp_valid = 1'b1; lsu_rdata = 32'h0000_0033;
        exp_q.push_back(mk_unexp());
        tick();
        lsu_resp_valid = 1'b0; lsu_rdata = 32'h0;
        tick();

        // Saturating stall counter: 20 wait cycles with a 4-bit counter
        issue(WB_INSTR_LOAD, 1'b1, 5'd10, 32'h0);
        exp_q.push_back(mk(1'b1, 5'd10, 32'h0000_0001, 1'b0, 4'd15));
        tick();
        idle_in();
        for (int i = 0; i < 20; i++) begin
            if (i == 15 || i == 19) begin
                @(negedge clk);
                check("sat_stall", {28'h0, stall_cnt}, 32'd15);
            end
            tick();
        end
        lsu_resp_valid = 1'b1; lsu_rdata = 32'h0000_0001;
        tick();
        lsu_resp_valid = 1'b0; lsu_rdata = 32'h0;
        @(negedge clk); check("stall_hold_after_retire", {28'h0, stall_cnt}, 32'd15);
        repeat (3) tick();

        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
